// File: rtl/solver_scheduler.sv
// solver_scheduler: dispatches jobs (limb data plus configuration) to a pool
// of solver instances over shared write buses, tracks per-solver busy/done
// state, and returns completed results through a round-robin result port.
module solver_scheduler #(
   parameter int unsigned NUM_SOLVERS     = 4,
   parameter int unsigned LIMB_INDEX_BITS = 6,
   parameter int unsigned LIMB_SIZE_BITS  = 27,
   parameter int unsigned TAG_BITS        = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   // job request
   input  logic                          job_valid,
   output logic                          job_ready,
   input  logic [TAG_BITS-1:0]           job_tag,
   input  logic [LIMB_INDEX_BITS-1:0]    job_num_limbs,
   input  logic [15:0]                   job_iter_lim,
   // limb stream
   input  logic                          limb_valid,
   output logic                          limb_ready,
   input  logic [LIMB_SIZE_BITS-1:0]     limb_re,
   input  logic [LIMB_SIZE_BITS-1:0]     limb_im,
   // shared solver write buses
   output logic [LIMB_INDEX_BITS-1:0]    sl_wr_index,
   output logic [LIMB_SIZE_BITS-1:0]     sl_real_data,
   output logic [LIMB_SIZE_BITS-1:0]     sl_imag_data,
   output logic [LIMB_INDEX_BITS-1:0]    sl_num_limbs_data,
   output logic [15:0]                   sl_iter_lim_data,
   // per-solver controls
   output logic [NUM_SOLVERS-1:0]        sl_wr_real_en,
   output logic [NUM_SOLVERS-1:0]        sl_wr_imag_en,
   output logic [NUM_SOLVERS-1:0]        sl_wr_num_limbs_en,
   output logic [NUM_SOLVERS-1:0]        sl_wr_iter_lim_en,
   output logic [NUM_SOLVERS-1:0]        sl_start,
   input  logic [NUM_SOLVERS-1:0]        sl_out_ready,
   input  logic [16*NUM_SOLVERS-1:0]     sl_iterations,
   // result port
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [TAG_BITS-1:0]           res_tag,
   output logic [15:0]                   res_iterations,
   output logic [2:0]                    res_solver
);

   localparam int unsigned N = NUM_SOLVERS;
   localparam logic [LIMB_INDEX_BITS-1:0] IDX_ONE = LIMB_INDEX_BITS'(1);

   typedef enum logic [1:0] {IDLE, LOAD, CONFIG, START} state_t;

   state_t                       state_q, state_d;
   logic [N-1:0]                 busy_q, done_q, ordy_q, sel_oh, rise;
   logic [2:0]                   rr_ptr_q, res_ptr_q, target_q, free_sel, done_sel;
   logic                         free_found, done_found;
   logic [LIMB_INDEX_BITS-1:0]   idx_q, num_limbs_q;
   logic [15:0]                  iter_lim_q;
   logic [TAG_BITS-1:0]          tag_q [N];
   logic [15:0]                  iters_q [N];
   logic [TAG_BITS-1:0]          done_tag;
   logic [15:0]                  done_iters;
   logic                         job_hs, res_hs;

   // First set bit of mask at or after ptr, wrapping; returns {found, index}.
   function automatic logic [3:0] pick_from(input logic [N-1:0] mask, input logic [2:0] ptr);
      int unsigned best_d;
      int unsigned d;
      logic [2:0]  sel;
      best_d = N;
      sel    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         d = (i + N - 32'(ptr)) % N;
         if (mask[i] && d < best_d) begin
            best_d = d;
            sel    = 3'(i);
         end
      end
      return {best_d < N, sel};
   endfunction

   function automatic logic [2:0] ptr_next(input logic [2:0] p);
      return (p == 3'(N - 1)) ? 3'd0 : p + 3'd1;
   endfunction

   assign {free_found, free_sel} = pick_from(~busy_q, rr_ptr_q);
   assign {done_found, done_sel} = pick_from(done_q, res_ptr_q);

   // Gated by reset so job_ready stays low while reset is held.
   assign job_ready = reset & (state_q == IDLE) & free_found;
   assign job_hs    = job_valid & job_ready;
   assign res_hs    = res_valid & res_ready;
   assign rise      = sl_out_ready & ~ordy_q;

   // Target one-hot and payload mux of the solver chosen by the result arbiter.
   always_comb begin
      sel_oh     = '0;
      done_tag   = '0;
      done_iters = '0;
      for (int unsigned i = 0; i < N; i++) begin
         sel_oh[i] = (3'(i) == target_q);
         if (3'(i) == done_sel) begin
            done_tag   = tag_q[i];
            done_iters = iters_q[i];
         end
      end
   end

   // Dispatch FSM next-state and solver bus/enable decode.
   always_comb begin
      state_d            = state_q;
      limb_ready         = 1'b0;
      sl_wr_index        = '0;
      sl_real_data       = '0;
      sl_imag_data       = '0;
      sl_num_limbs_data  = '0;
      sl_iter_lim_data   = '0;
      sl_wr_real_en      = '0;
      sl_wr_imag_en      = '0;
      sl_wr_num_limbs_en = '0;
      sl_wr_iter_lim_en  = '0;
      sl_start           = '0;
      unique case (state_q)
         IDLE: begin
            if (job_hs) state_d = (job_num_limbs == '0) ? CONFIG : LOAD;
         end
         LOAD: begin
            limb_ready = 1'b1;
            if (limb_valid) begin
               sl_wr_index   = idx_q;
               sl_real_data  = limb_re;
               sl_imag_data  = limb_im;
               sl_wr_real_en = sel_oh;
               sl_wr_imag_en = sel_oh;
               if (idx_q == num_limbs_q - IDX_ONE) state_d = CONFIG;
            end
         end
         CONFIG: begin
            sl_num_limbs_data  = num_limbs_q;
            sl_iter_lim_data   = iter_lim_q;
            sl_wr_num_limbs_en = sel_oh;
            sl_wr_iter_lim_en  = sel_oh;
            state_d            = START;
         end
         START: begin
            sl_start = sel_oh;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Dispatch state register, job latches, limb index and round-robin pointer.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         num_limbs_q <= '0;
         iter_lim_q  <= '0;
         target_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         state_q <= state_d;
         if (job_hs) begin
            num_limbs_q <= job_num_limbs;
            iter_lim_q  <= job_iter_lim;
            target_q    <= free_sel;
            idx_q       <= '0;
         end
         if (state_q == LOAD && limb_valid) idx_q <= idx_q + IDX_ONE;
         if (state_q == START) rr_ptr_q <= ptr_next(target_q);
      end
   end

   // Per-solver busy/done tracking; dispatch, completion and result release
   // touch distinct solvers in any one cycle, so all three may act together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy_q <= '0;
         done_q <= '0;
         ordy_q <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            tag_q[i]   <= '0;
            iters_q[i] <= '0;
         end
      end else begin
         ordy_q <= sl_out_ready;
         for (int unsigned i = 0; i < N; i++) begin
            if (job_hs && free_sel == 3'(i)) begin
               busy_q[i] <= 1'b1;
               tag_q[i]  <= job_tag;
            end
            if (res_hs && res_solver == 3'(i)) begin
               busy_q[i] <= 1'b0;
               done_q[i] <= 1'b0;
            end
            if (rise[i] && busy_q[i] && !done_q[i]) begin
               done_q[i]  <= 1'b1;
               iters_q[i] <= sl_iterations[16*i +: 16];
            end
         end
      end
   end

   // Result arbiter: load one done solver when idle, hold until accepted.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         res_valid      <= 1'b0;
         res_tag        <= '0;
         res_iterations <= '0;
         res_solver     <= '0;
         res_ptr_q      <= '0;
      end else if (res_valid) begin
         if (res_ready) begin
            res_valid <= 1'b0;
            res_ptr_q <= ptr_next(res_solver);
         end
      end else if (done_found) begin
         res_valid      <= 1'b1;
         res_tag        <= done_tag;
         res_iterations <= done_iters;
         res_solver     <= done_sel;
      end
   end

endmodule

// File: tb/tb_solver_scheduler.sv
// Scoreboard bench for solver_scheduler: stimulus pushes expected solver-bus
// events and results into queues; monitors pop and compare on the falling edge.
module tb_solver_scheduler;

   localparam int NS = 4;

   logic          clock, reset;
   logic          job_valid, job_ready;
   logic [15:0]   job_tag;
   logic [5:0]    job_num_limbs;
   logic [15:0]   job_iter_lim;
   logic          limb_valid, limb_ready;
   logic [26:0]   limb_re, limb_im;
   logic [5:0]    sl_wr_index, sl_num_limbs_data;
   logic [26:0]   sl_real_data, sl_imag_data;
   logic [15:0]   sl_iter_lim_data;
   logic [3:0]    sl_wr_real_en, sl_wr_imag_en, sl_wr_num_limbs_en, sl_wr_iter_lim_en, sl_start;
   logic [3:0]    sl_out_ready;
   logic [63:0]   sl_iterations;
   logic          res_valid, res_ready;
   logic [15:0]   res_tag, res_iterations;
   logic [2:0]    res_solver;

   typedef logic [101:0] ev_t;
   typedef struct packed {
      logic [15:0] tag;
      logic [15:0] it;
      logic [2:0]  s;
   } res_t;

   ev_t  exp_wr[$];
   res_t exp_res[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   solver_scheduler #(
      .NUM_SOLVERS(NS), .LIMB_INDEX_BITS(6), .LIMB_SIZE_BITS(27), .TAG_BITS(16)
   ) dut (
      .clock(clock), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready), .job_tag(job_tag),
      .job_num_limbs(job_num_limbs), .job_iter_lim(job_iter_lim),
      .limb_valid(limb_valid), .limb_ready(limb_ready), .limb_re(limb_re), .limb_im(limb_im),
      .sl_wr_index(sl_wr_index), .sl_real_data(sl_real_data), .sl_imag_data(sl_imag_data),
      .sl_num_limbs_data(sl_num_limbs_data), .sl_iter_lim_data(sl_iter_lim_data),
      .sl_wr_real_en(sl_wr_real_en), .sl_wr_imag_en(sl_wr_imag_en),
      .sl_wr_num_limbs_en(sl_wr_num_limbs_en), .sl_wr_iter_lim_en(sl_wr_iter_lim_en),
      .sl_start(sl_start), .sl_out_ready(sl_out_ready), .sl_iterations(sl_iterations),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag),
      .res_iterations(res_iterations), .res_solver(res_solver)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   function automatic ev_t mk_ev(input logic [3:0] re_en, input logic [3:0] im_en,
                                 input logic [3:0] nl_en, input logic [3:0] il_en,
                                 input logic [3:0] st, input logic [5:0] idx,
                                 input logic [26:0] re, input logic [26:0] im,
                                 input logic [5:0] nl, input logic [15:0] il);
      return {re_en, im_en, nl_en, il_en, st, idx, re, im, nl, il};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", nm, act, exp);
      end
   endtask

   task automatic push_load(input int t, input int idx, input logic [26:0] re, input logic [26:0] im);
      logic [3:0] oh;
      oh = 4'(1 << t);
      exp_wr.push_back(mk_ev(oh, oh, 4'h0, 4'h0, 4'h0, 6'(idx), re, im, 6'h0, 16'h0));
   endtask

   task automatic push_cfg(input int t, input logic [5:0] nl, input logic [15:0] il);
      logic [3:0] oh;
      oh = 4'(1 << t);
      exp_wr.push_back(mk_ev(4'h0, 4'h0, oh, oh, 4'h0, 6'h0, 27'h0, 27'h0, nl, il));
   endtask

   task automatic push_start(input int t);
      logic [3:0] oh;
      oh = 4'(1 << t);
      exp_wr.push_back(mk_ev(4'h0, 4'h0, 4'h0, 4'h0, oh, 6'h0, 27'h0, 27'h0, 6'h0, 16'h0));
   endtask

   task automatic push_res(input logic [15:0] tag, input logic [15:0] it, input logic [2:0] s);
      res_t r;
      r.tag = tag;
      r.it  = it;
      r.s   = s;
      exp_res.push_back(r);
   endtask

   // Solver bus monitor
   always @(negedge clock) begin : wr_mon
      ev_t act;
      ev_t e;
      act = mk_ev(sl_wr_real_en, sl_wr_imag_en, sl_wr_num_limbs_en, sl_wr_iter_lim_en,
                  sl_start, sl_wr_index, sl_real_data, sl_imag_data, sl_num_limbs_data,
                  sl_iter_lim_data);
      n_cmp++;
      if (|{sl_wr_real_en, sl_wr_imag_en, sl_wr_num_limbs_en, sl_wr_iter_lim_en, sl_start}) begin
         if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL wr_event: actual %h required no event", act);
         end else begin
            e = exp_wr.pop_front();
            if (act !== e) begin
               n_fail++;
               $display("FAIL wr_event: actual %h required %h", act, e);
            end
         end
      end else if (act !== '0) begin
         n_fail++;
         $display("FAIL bus_idle: actual %h required 0", act);
      end
   end

   // Result monitor: payload must match the head entry every valid cycle.
   always @(negedge clock) begin : res_mon
      res_t ar;
      res_t er;
      if (res_valid) begin
         ar = {res_tag, res_iterations, res_solver};
         n_cmp++;
         if (exp_res.size() == 0) begin
            n_fail++;
            $display("FAIL result: actual %h required no result", ar);
         end else begin
            if (ar !== exp_res[0]) begin
               n_fail++;
               $display("FAIL result: actual %h required %h", ar, exp_res[0]);
            end
            if (res_ready) er = exp_res.pop_front();
         end
      end
   end

   task automatic do_job(input logic [15:0] tag, input logic [5:0] nl, input logic [15:0] il);
      logic hs;
      hs            = 1'b0;
      job_tag       = tag;
      job_num_limbs = nl;
      job_iter_lim  = il;
      job_valid     = 1'b1;
      for (int c = 0; c < 400 && !hs; c++) begin
         @(negedge clock);
         hs = job_ready;
         @(posedge clock); #1;
      end
      job_valid = 1'b0;
      check("job_handshake", 32'(hs), 32'd1);
   endtask

   task automatic do_limb(input logic [26:0] re, input logic [26:0] im, input int gap);
      logic hs;
      hs = 1'b0;
      limb_valid = 1'b0;
      repeat (gap) begin @(posedge clock); #1; end
      limb_re    = re;
      limb_im    = im;
      limb_valid = 1'b1;
      for (int c = 0; c < 400 && !hs; c++) begin
         @(negedge clock);
         hs = limb_ready;
         @(posedge clock); #1;
      end
      limb_valid = 1'b0;
      limb_re    = '0;
      limb_im    = '0;
      check("limb_handshake", 32'(hs), 32'd1);
   endtask

   task automatic job_n(input logic [15:0] tag, input logic [15:0] il, input int t,
                        input int n, input logic [26:0] base, input int gap);
      for (int k = 0; k < n; k++)
         push_load(t, k, 27'(base + 27'(k)), 27'(base + 27'(k) + 27'h100));
      push_cfg(t, 6'(n), il);
      push_start(t);
      do_job(tag, 6'(n), il);
      for (int k = 0; k < n; k++)
         do_limb(27'(base + 27'(k)), 27'(base + 27'(k) + 27'h100), gap);
   endtask

   // Zero-limb job: CONFIG must follow the handshake, START the cycle after.
   task automatic job0(input logic [15:0] tag, input logic [15:0] il, input int t);
      logic [3:0] oh;
      oh = 4'(1 << t);
      push_cfg(t, 6'h0, il);
      push_start(t);
      do_job(tag, 6'h0, il);
      @(negedge clock);
      check("z_cfg_en", 32'(sl_wr_num_limbs_en), 32'(oh));
      check("z_cfg_no_start", 32'(sl_start), 32'd0);
      @(negedge clock);
      check("z_start", 32'(sl_start), 32'(oh));
      check("z_start_no_cfg", 32'(sl_wr_num_limbs_en), 32'd0);
      @(posedge clock); #1;
   endtask

   task automatic complete(input int a, input logic [15:0] ia, input int b, input logic [15:0] ib);
      sl_iterations[16*a +: 16] = ia;
      sl_out_ready[a] = 1'b1;
      if (b >= 0) begin
         sl_iterations[16*b +: 16] = ib;
         sl_out_ready[b] = 1'b1;
      end
      @(posedge clock); #1;
      sl_out_ready = '0;
   endtask

   task automatic wait_drain(input string nm);
      int c;
      c = 0;
      while ((exp_wr.size() != 0 || exp_res.size() != 0) && c < 300) begin
         @(posedge clock); #1;
         c++;
      end
      check({nm, "_drain"}, 32'(exp_wr.size() + exp_res.size()), 32'd0);
   endtask

   task automatic pulse_reset();
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (2) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      reset         = 1'b0;
      job_valid     = 1'b0;
      job_tag       = '0;
      job_num_limbs = '0;
      job_iter_lim  = '0;
      limb_valid    = 1'b0;
      limb_re       = '0;
      limb_im       = '0;
      sl_out_ready  = '0;
      sl_iterations = '0;
      res_ready     = 1'b1;

      // Reset state
      #3;
      check("rst_job_ready", 32'(job_ready), 32'd0);
      check("rst_limb_ready", 32'(limb_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_start", 32'(sl_start), 32'd0);
      repeat (2) begin @(posedge clock); #1; end
      reset = 1'b1;
      @(negedge clock);
      check("rel_job_ready", 32'(job_ready), 32'd1);
      @(posedge clock); #1;

      // Two-limb job on solver 0, completion with 57 iterations
      push_res(16'h0011, 16'd57, 3'd0);
      job_n(16'h0011, 16'd100, 0, 2, 27'h000A0, 0);
      complete(0, 16'd57, -1, 16'd0);
      wait_drain("t1");

      // Five jobs, four solvers: fifth waits for solver 2 to be released
      pulse_reset();
      for (int j = 0; j < 4; j++)
         job_n(16'(16'h0100 + j), 16'(200 + j), j, 1, 27'(27'h1000 + 27'(j * 16)), 0);
      fork
         job_n(16'h0104, 16'd300, 2, 1, 27'h2000, 0);
         begin
            repeat (4) begin
               @(negedge clock);
               check("full_job_ready", 32'(job_ready), 32'd0);
            end
            @(posedge clock); #1;
            push_res(16'h0102, 16'd33, 3'd2);
            complete(2, 16'd33, -1, 16'd0);
         end
      join
      wait_drain("t2");

      // Simultaneous completion on solvers 1 and 3 with res_ready held low
      pulse_reset();
      for (int j = 0; j < 4; j++) job0(16'(16'h0200 + j), 16'(16'h20 + j), j);
      res_ready = 1'b0;
      push_res(16'h0201, 16'd11, 3'd1);
      push_res(16'h0203, 16'd13, 3'd3);
      complete(1, 16'd11, 3, 16'd13);
      repeat (10) begin @(posedge clock); #1; end
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_solver", 32'(res_solver), 32'd1);
      res_ready = 1'b1;
      wait_drain("t3a");
      push_res(16'h0200, 16'd10, 3'd0);
      push_res(16'h0202, 16'd12, 3'd2);
      complete(0, 16'd10, 2, 16'd12);
      wait_drain("t3b");

      // Gapped limb stream on solver 0
      push_res(16'h0300, 16'd77, 3'd0);
      job_n(16'h0300, 16'd500, 0, 4, 27'h3000, 3);
      complete(0, 16'd77, -1, 16'd0);
      wait_drain("t4");

      // Zero-limb job, next round-robin solver is 1
      push_res(16'h0400, 16'd5, 3'd1);
      job0(16'h0400, 16'd7, 1);
      complete(1, 16'd5, -1, 16'd0);
      wait_drain("t5");

      // Reset in the middle of LOAD (solver 2, idx 1)
      push_load(2, 0, 27'h4000, 27'h4100);
      do_job(16'h0500, 6'd3, 16'd50);
      do_limb(27'h4000, 27'h4100, 0);
      limb_re    = 27'h4001;
      limb_im    = 27'h4101;
      limb_valid = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("mid_rst_job_ready", 32'(job_ready), 32'd0);
      check("mid_rst_limb_ready", 32'(limb_ready), 32'd0);
      check("mid_rst_wr_en", 32'({sl_wr_real_en, sl_wr_imag_en}), 32'd0);
      check("mid_rst_start", 32'(sl_start), 32'd0);
      check("mid_rst_res_valid", 32'(res_valid), 32'd0);
      repeat (2) begin @(posedge clock); #1; end
      limb_valid = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      check("post_rst_job_ready", 32'(job_ready), 32'd1);
      check("post_rst_limb_ready", 32'(limb_ready), 32'd0);
      @(posedge clock); #1;
      push_res(16'h0600, 16'd99, 3'd0);
      job_n(16'h0600, 16'd9, 0, 1, 27'h5000, 0);
      complete(0, 16'd99, -1, 16'd0);
      wait_drain("t6");

      repeat (3) begin @(posedge clock); #1; end
      check("final_wr_queue", 32'(exp_wr.size()), 32'd0);
      check("final_res_queue", 32'(exp_res.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/solver_scheduler.md
SOLVER_SCHEDULER -- requirements
Module: solver_scheduler

Interface
REQ-001 SHALL have parameter NUM_SOLVERS, default 4, number of attached solver instances (2..8).
REQ-002 SHALL have parameter LIMB_INDEX_BITS, default 6, limb index width.
REQ-003 SHALL have parameter LIMB_SIZE_BITS, default 27, limb data width.
REQ-004 SHALL have parameter TAG_BITS, default 16, job tag width.
REQ-005 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have job ports: job_valid in 1; job_ready out 1; job_tag in TAG_BITS; job_num_limbs in LIMB_INDEX_BITS; job_iter_lim in 16.
REQ-007 SHALL have limb ports: limb_valid in 1; limb_ready out 1; limb_re in LIMB_SIZE_BITS; limb_im in LIMB_SIZE_BITS.
REQ-008 SHALL have shared solver write buses (out): sl_wr_index LIMB_INDEX_BITS; sl_real_data, sl_imag_data LIMB_SIZE_BITS; sl_num_limbs_data LIMB_INDEX_BITS; sl_iter_lim_data 16.
REQ-009 SHALL have per-solver outputs, NUM_SOLVERS wide, bit i = solver i: sl_wr_real_en, sl_wr_imag_en, sl_wr_num_limbs_en, sl_wr_iter_lim_en, sl_start.
REQ-010 SHALL have per-solver inputs: sl_out_ready NUM_SOLVERS; sl_iterations 16*NUM_SOLVERS (solver i at bits [16i+15:16i]).
REQ-011 SHALL have result ports: res_valid out 1; res_ready in 1; res_tag out TAG_BITS; res_iterations out 16; res_solver out 3.

Function
REQ-012 Dispatch FSM SHALL have states IDLE, LOAD, CONFIG, START.
REQ-013 job_ready SHALL be 1 only in IDLE with at least one solver whose busy bit is 0 (registered busy, not same-cycle frees).
REQ-014 On job handshake: latch tag/num_limbs/iter_lim; target = first free solver at or after rr_ptr (wrapping); set busy[target], tag[target]; idx=0; go LOAD, or CONFIG if job_num_limbs==0.
REQ-015 LOAD: limb_ready=1; on limb handshake, same cycle, sl_wr_index=idx, sl_real_data=limb_re, sl_imag_data=limb_im, sl_wr_real_en[target]=sl_wr_imag_en[target]=1; idx increments; after handshake with idx==num_limbs-1 go CONFIG.
REQ-016 LOAD with limb_valid=0: no write enables, stay in LOAD indefinitely.
REQ-017 CONFIG: exactly one cycle, sl_wr_num_limbs_en[target]=sl_wr_iter_lim_en[target]=1, buses carry latched num_limbs/iter_lim; go START.
REQ-018 START: exactly one cycle, sl_start[target]=1; rr_ptr=(target+1) mod NUM_SOLVERS; go IDLE.
REQ-019 All enables/start for non-target solvers SHALL be 0; shared data buses SHALL be 0 in cycles with no write enable.
REQ-020 Completion: sl_out_ready registered per solver; rising edge on solver i with busy[i]=1 and done[i]=0 SHALL set done[i] and capture sl_iterations[i]; edges on non-busy solvers ignored.
REQ-021 Result arbiter: when res_valid=0 and any done bit set, next cycle SHALL present the done solver at or after res_ptr (wrapping): res_valid=1, res_tag=tag[i], res_iterations=captured value, res_solver=i.
REQ-022 res_valid and payload SHALL hold stable until res_ready=1; on handshake clear done[i] and busy[i], res_ptr=(i+1) mod NUM_SOLVERS, res_valid=0 next cycle.
REQ-023 Simultaneous completion and result handshake on different solvers SHALL both take effect; a solver freed by handshake is eligible for job_ready the following cycle.
REQ-024 Dispatch and result paths SHALL operate concurrently and independently.
REQ-025 Maximum one job in dispatch at a time; all solvers busy SHALL hold job_ready=0 without loss.

Reset
REQ-026 reset low SHALL asynchronously force: state IDLE; busy, done, registered out_ready, rr_ptr, res_ptr, idx = 0; all outputs 0 (job_ready becomes 1 only after deassertion).
REQ-027 Reset mid-LOAD or mid-result SHALL abandon job/result; no enable or start pulse issued after reset.

Verification
REQ-028 2-limb job tag 0x0011, iter_lim 100, all free -> solver0 writes idx0,idx1, CONFIG cycle, single sl_start[0]; out_ready edge with iterations 57 -> res_tag 0x0011, res_iterations 57, res_solver 0.
REQ-029 5 jobs back-to-back, 4 solvers, no completions -> targets 0,1,2,3; job_ready=0 after 4th START; complete solver2 and accept result -> 5th job dispatched to solver2.
REQ-030 Solvers 1 and 3 complete same cycle, res_ready held 0 for 10 cycles -> res_valid stable on solver1 payload; after handshake solver3 presented next.
REQ-031 limb_valid gaps of 3 cycles between limbs -> no spurious write enables, sl_wr_index contiguous 0..N-1.
REQ-032 job_num_limbs=0 -> no limb writes, CONFIG then START in consecutive cycles.
REQ-033 reset asserted during LOAD idx 1 -> all outputs 0 immediately; after release, busy cleared and job_ready=1.
